// File: rtl/flow_table_port_arbiter_pkg.sv
// Shared flow-table definitions: arbiter state, lock timeout, default widths,
// read-tag layout and a saturating counter helper.
package netflow_pkg;

    localparam int FT_ADDR_W    = 12;
    localparam int FT_DATA_W    = 241;
    localparam int LOCK_TIMEOUT = 64;
    localparam int LOCK_TMR_W   = $clog2(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // One in-flight read: valid flag plus the requester it belongs to.
    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    // Add a small increment to a 32-bit count, sticking at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/flow_table_port_arbiter_if.sv
// Requester/response handshakes and the shared BRAM port of the flow table.
// master = requesters + BRAM side, slave = the arbiter.
interface flow_table_port_arbiter_if
    import netflow_pkg::*;
#(
    parameter int ADDR_W = FT_ADDR_W,
    parameter int DATA_W = FT_DATA_W
);
    logic              req0_valid, req0_ready, req0_we, req0_lock;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid, req1_ready, req1_we, req1_lock;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_di;
    logic [DATA_W-1:0] mem_do;

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output mem_do,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_di
    );

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  mem_do,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_di
    );
endinterface

// File: rtl/flow_table_port_arbiter_rd_tag_pipe.sv
// Read-tag delay line matching the BRAM read latency (RD_LAT 1..3).
// A tag pushed in the grant cycle pops out exactly RD_LAT cycles later.
module rd_tag_pipe
    import netflow_pkg::*;
#(
    parameter int RD_LAT = 1
)(
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push,
    output rd_tag_t pop
);
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] id_pipe;

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= push.vld;
            id_pipe[0]  <= push.id;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign pop = '{vld: vld_pipe[RD_LAT-1], id: id_pipe[RD_LAT-1]};

endmodule

// File: rtl/flow_table_port_arbiter.sv
// Two-requester arbiter for the single flow-table BRAM port.
// Requester 0 = update engine, 1 = expiry scanner. Round-robin on contention,
// optional port lock for read-modify-write with an idle timeout.
module flow_table_port_arbiter
    import netflow_pkg::*;
#(
    parameter int ADDR_W = FT_ADDR_W,
    parameter int DATA_W = FT_DATA_W,
    parameter int RD_LAT = 1
)(
    input  logic                      ACLK,
    input  logic                      ARESET,
    flow_table_port_arbiter_if.slave  bus,
    output logic [31:0]               stall_count
);
    arb_state_e              state_q, state_d;
    logic                    last_gnt_q, last_gnt_d;
    logic [LOCK_TMR_W-1:0]   lock_tmr_q, lock_tmr_d;
    logic                    gnt0, gnt1;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       di_q;
    logic [DATA_W-1:0]       rdata0_q, rdata1_q;
    logic [31:0]             stall_q;
    logic [1:0]              stall_inc;
    rd_tag_t                 tag_in, tag_out;

    // Arbiter state, round-robin pointer and lock idle timer.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            lock_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lock_tmr_q <= lock_tmr_d;
        end
    end

    // Grant selection and next-state; no grant at all while in reset.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_tmr_d = '0;
        if (!ARESET) begin
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        gnt0 = last_gnt_q;
                        gnt1 = !last_gnt_q;
                    end else begin
                        gnt0 = bus.req0_valid;
                        gnt1 = bus.req1_valid;
                    end
                end
                LOCK0:   gnt0 = bus.req0_valid;
                LOCK1:   gnt1 = bus.req1_valid;
                default: ;
            endcase
        end
        if (gnt0) begin
            last_gnt_d = 1'b0;
            state_d    = bus.req0_lock ? LOCK0 : IDLE;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
            state_d    = bus.req1_lock ? LOCK1 : IDLE;
        end else if (state_q != IDLE) begin
            // Owner went quiet: give the port back after LOCK_TIMEOUT idle cycles.
            if (lock_tmr_q == LOCK_TMR_W'(LOCK_TIMEOUT - 1))
                state_d = IDLE;
            else
                lock_tmr_d = lock_tmr_q + LOCK_TMR_W'(1);
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mem_en     = gnt0 | gnt1;
    assign bus.mem_we     = (gnt0 & bus.req0_we) | (gnt1 & bus.req1_we);
    assign bus.mem_addr   = gnt0 ? bus.req0_addr  : gnt1 ? bus.req1_addr  : addr_q;
    assign bus.mem_di     = gnt0 ? bus.req0_wdata : gnt1 ? bus.req1_wdata : di_q;

    // Address/data bus hold the last driven value between grants.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q <= '0;
            di_q   <= '0;
        end else begin
            addr_q <= bus.mem_addr;
            di_q   <= bus.mem_di;
        end
    end

    assign tag_in = '{vld: (gnt0 & ~bus.req0_we) | (gnt1 & ~bus.req1_we), id: gnt1};

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
        .clk  (ACLK),
        .rst  (ARESET),
        .push (tag_in),
        .pop  (tag_out)
    );

    // Responses are masked during reset so a late tag can never leak out.
    assign bus.rsp0_valid = !ARESET & tag_out.vld & !tag_out.id;
    assign bus.rsp1_valid = !ARESET & tag_out.vld &  tag_out.id;
    assign bus.rsp0_rdata = bus.rsp0_valid ? bus.mem_do : rdata0_q;
    assign bus.rsp1_rdata = bus.rsp1_valid ? bus.mem_do : rdata1_q;

    // Response data holders so rdata stays put between responses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= bus.rsp0_rdata;
            rdata1_q <= bus.rsp1_rdata;
        end
    end

    assign stall_inc = {1'b0, bus.req0_valid & ~gnt0} + {1'b0, bus.req1_valid & ~gnt1};

    // Saturating count of refused requester-cycles.
    always_ff @(posedge ACLK) begin
        if (ARESET) stall_q <= '0;
        else        stall_q <= sat_add32(stall_q, stall_inc);
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_flow_table_port_arbiter.sv
// Bench for flow_table_port_arbiter: directed scenarios plus random traffic,
// a behavioural arbiter model, an environment BRAM and a response scoreboard.
module tb_flow_table_port_arbiter;
    import netflow_pkg::*;

    localparam int ADDR_W = FT_ADDR_W;
    localparam int DATA_W = FT_DATA_W;
    localparam int RD_LAT = 2;
    localparam int TMO    = LOCK_TIMEOUT;

    typedef logic [DATA_W-1:0] data_t;
    typedef struct {
        int    due;
        int    id;
        data_t data;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] stall_count;

    always #5 ACLK = ~ACLK;

    flow_table_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    flow_table_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .bus         (bus),
        .stall_count (stall_count)
    );

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic data_t pat(input int a);
        logic [255:0] w;
        w = {8{32'(a) ^ 32'hC0DE_0000}};
        return DATA_W'(w);
    endfunction

    function automatic data_t rnd_data();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return DATA_W'(w);
    endfunction

    // Environment BRAM: read-first, RD_LAT-cycle output pipeline.
    data_t env_mem [0:255];
    data_t dpipe   [RD_LAT];
    logic  env_init = 1'b0;
    always @(posedge ACLK) begin
        if (!env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= pat(i);
            env_init <= 1'b1;
        end else if (bus.mem_en) begin
            dpipe[0] <= env_mem[bus.mem_addr[7:0]];
            if (bus.mem_we) env_mem[bus.mem_addr[7:0]] <= bus.mem_di;
        end
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bus.mem_do = dpipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model state: port owner (-1 = free), tie-break winner,
    // idle cycles while owned, expected stall count, last bus values.
    data_t       ref_mem [0:255];
    exp_t        expq [$];
    int          owner = -1;
    int          prefer = 0;
    int          idle = 0;
    longint      exp_stall = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    data_t       exp_di = '0;
    logic [1:0]  act_gnt;

    task automatic do_cycle(input bit rst,
                            input bit v0, input bit we0, input bit lk0, input int a0,
                            input bit v1, input bit we1, input bit lk1, input int a1);
        data_t d0, d1;
        int    gw, stalls;
        d0 = rnd_data();
        d1 = rnd_data();
        @(negedge ACLK);
        ARESET = rst;
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_lock = lk0;
        bus.req0_addr = ADDR_W'(a0); bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_lock = lk1;
        bus.req1_addr = ADDR_W'(a1); bus.req1_wdata = d1;
        #1;
        gw = -1;
        if (!rst) begin
            if (owner < 0) begin
                if (v0 && v1) gw = prefer;
                else if (v0)  gw = 0;
                else if (v1)  gw = 1;
            end else if (owner == 0 && v0) begin
                gw = 0;
            end else if (owner == 1 && v1) begin
                gw = 1;
            end
        end
        chk("req0_ready", bus.req0_ready, gw == 0);
        chk("req1_ready", bus.req1_ready, gw == 1);
        chk("mem_en", bus.mem_en, gw >= 0);
        chk("mem_we", bus.mem_we, gw == 0 ? we0 : (gw == 1 ? we1 : 1'b0));
        chk("mem_addr", bus.mem_addr, gw == 0 ? ADDR_W'(a0) : (gw == 1 ? ADDR_W'(a1) : exp_addr));
        chk("mem_di", bus.mem_di, gw == 0 ? d0 : (gw == 1 ? d1 : exp_di));
        chk("stall_count", stall_count, exp_stall[31:0]);
        act_gnt = {bus.req1_ready, bus.req0_ready};
        if (rst) begin
            owner = -1; prefer = 0; idle = 0; exp_stall = 0;
            exp_addr = '0; exp_di = '0;
            expq.delete();
        end else begin
            stalls = int'(v0 && gw != 0) + int'(v1 && gw != 1);
            exp_stall = exp_stall + stalls;
            if (exp_stall > 64'hFFFF_FFFF) exp_stall = 64'hFFFF_FFFF;
            if (gw >= 0) begin
                prefer = 1 - gw;
                idle   = 0;
                exp_addr = (gw == 0) ? ADDR_W'(a0) : ADDR_W'(a1);
                exp_di   = (gw == 0) ? d0 : d1;
                if ((gw == 0) ? we0 : we1)
                    ref_mem[exp_addr[7:0]] = exp_di;
                else
                    expq.push_back('{due: cyc + RD_LAT, id: gw, data: ref_mem[exp_addr[7:0]]});
                owner = ((gw == 0) ? lk0 : lk1) ? gw : -1;
            end else if (owner >= 0) begin
                idle++;
                if (idle == TMO) begin
                    owner = -1;
                    idle  = 0;
                end
            end
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response shows up.
    data_t hold [2];
    initial begin
        logic  rv;
        data_t rd;
        exp_t  e;
        hold[0] = '0;
        hold[1] = '0;
        forever begin
            @(posedge ACLK);
            if (ARESET) begin
                hold[0] = '0;
                hold[1] = '0;
            end
            @(negedge ACLK);
            #2;
            chk("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
            while (expq.size() > 0 && expq[0].due < cyc) begin
                n_vec++; n_err++;
                $display("FAIL rsp_missing: requester %0d response due cyc %0d not seen (now %0d)",
                         expq[0].id, expq[0].due, cyc);
                void'(expq.pop_front());
            end
            for (int r = 0; r < 2; r++) begin
                rv = (r == 0) ? bus.rsp0_valid : bus.rsp1_valid;
                rd = (r == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                if (rv) begin
                    if (expq.size() == 0 || expq[0].due != cyc || expq[0].id != r) begin
                        n_vec++; n_err++;
                        $display("FAIL rsp_unexpected: rsp%0d_valid=1 @cyc %0d, expected none", r, cyc);
                    end else begin
                        e = expq.pop_front();
                        chk(r == 0 ? "rsp0_rdata" : "rsp1_rdata", rd, e.data);
                        hold[r] = e.data;
                    end
                end else begin
                    chk(r == 0 ? "rsp0_rdata_hold" : "rsp1_rdata_hold", rd, hold[r]);
                end
            end
        end
    end

    initial begin
        logic [1:0] ord [4];
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        ARESET = 1'b1;
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_lock = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_lock = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        repeat (2) @(posedge ACLK);

        // Reset with both requesters asking: nothing may be granted.
        do_cycle(1, 1,0,0,1, 1,0,0,2);
        do_cycle(1, 0,0,0,0, 0,0,0,0);

        // Contention right after reset: 0,1,0,1 and four stalls.
        ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01; ord[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1,0,0,1+i, 1,0,0,8+i);
            chk("rr_order", act_gnt, ord[i]);
        end
        do_cycle(0, 0,0,0,0, 0,0,0,0);
        chk("stall_after_rr", stall_count, 32'd4);

        // Single read at 0x005, response RD_LAT later.
        do_cycle(0, 1,0,0,'h005, 0,0,0,0);
        repeat (RD_LAT + 1) do_cycle(0, 0,0,0,0, 0,0,0,0);

        // Requester 1 read-modify-write under lock while requester 0 waits.
        do_cycle(0, 1,0,0,3, 0,0,0,0);
        do_cycle(0, 1,0,0,3, 1,0,1,'h0A0);
        do_cycle(0, 1,0,0,3, 0,0,0,0);
        chk("lock_blocks_req0", act_gnt, 2'b00);
        do_cycle(0, 1,0,0,3, 0,0,0,0);
        do_cycle(0, 1,0,0,3, 1,1,0,'h0A0);
        chk("unlock_write", act_gnt, 2'b10);
        do_cycle(0, 1,0,0,3, 0,0,0,0);
        chk("req0_after_unlock", act_gnt, 2'b01);
        repeat (RD_LAT + 1) do_cycle(0, 0,0,0,0, 1,0,0,'h0A0);

        // Lock timeout: req0 locks then goes quiet for 64 cycles.
        do_cycle(1, 0,0,0,0, 0,0,0,0);
        do_cycle(0, 1,0,1,7, 1,0,0,9);
        for (int i = 1; i <= TMO + 1; i++) do_cycle(0, 0,0,0,0, 1,0,0,9);
        chk("timeout_grant1", act_gnt, 2'b10);

        // Reset right after a read grant: response must be discarded.
        repeat (RD_LAT + 1) do_cycle(0, 0,0,0,0, 0,0,0,0);
        do_cycle(0, 1,0,0,'h005, 0,0,0,0);
        do_cycle(1, 1,0,0,4, 1,0,0,6);
        do_cycle(0, 0,0,0,0, 0,0,0,0);
        chk("post_reset_addr", bus.mem_addr, '0);
        repeat (RD_LAT + 1) do_cycle(0, 0,0,0,0, 0,0,0,0);

        // Saturation: preload one below max, then keep stalling.
        do_cycle(1, 0,0,0,0, 0,0,0,0);
        do_cycle(0, 0,0,0,0, 0,0,0,0);
        @(negedge ACLK);
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        exp_stall = 64'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) do_cycle(0, 1,1,0,2, 1,1,0,3);
        chk("stall_saturated", stall_count, 32'hFFFF_FFFF);

        // Random traffic, with occasional resets.
        do_cycle(1, 0,0,0,0, 0,0,0,0);
        for (int k = 0; k < 1500; k++) begin
            do_cycle($urandom_range(0, 299) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 15),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 15));
        end

        // Drain: release any lock by timeout, let responses return.
        repeat (TMO + RD_LAT + 4) do_cycle(0, 0,0,0,0, 0,0,0,0);
        chk("scoreboard_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
